vector_lane_fu_sequencer: RTL and testbench

- Per-lane controller that sequences one vector instruction across the lane's elements.
- Steps the element index for the lane, pulses the start strobe of the selected functional unit (arithmetic, multiply, divide, mask), waits for multi-cycle completion, and issues one element write-enable per active element.
- Sits between vector decode/issue and the lane's functional units. It drives their offset/start inputs and reports busy/done back to the pipeline.

---
 rtl/rv32i_types_pkg.sv | 19 +
 rtl/vector_lane_fu_sequencer.sv | 149 ++++++++++++++
 tb/tb_vector_lane_fu_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types_pkg.sv
// Enums shared by the vector lane sequencer: functional-unit select and FSM states.
package rv32i_types_pkg;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MUL  = 2'd1,
    FU_DIV  = 2'd2,
    FU_MASK = 2'd3
  } lane_fu_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FIN    = 3'd4
  } lane_seq_state_t;

endpackage

// File: rtl/vector_lane_fu_sequencer.sv
// Per-lane sequencer: walks this lane's elements of one vector instruction,
// pulses the selected FU start, waits for multi-cycle units and commits results.
module vector_lane_fu_sequencer
  import rv32i_types_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int LANE_ID   = 0,
  parameter int VLMAX     = 32,
  parameter int VLW       = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       fu_sel,
  input  logic [VLW-1:0]   vl,
  input  logic             is_masked,
  input  logic [VLMAX-1:0] mask_bits,
  input  logic             done_mu,
  input  logic             done_du,
  input  logic             fu_exception,
  input  logic             stall_e_m,
  input  logic             flush,
  output logic             start_a,
  output logic             start_mu,
  output logic             start_div,
  output logic             start_ma,
  output logic [VLW-1:0]   offset,
  output logic             elem_wen,
  output logic             busy,
  output logic             next_busy,
  output logic             instr_done,
  output logic             exception
);

  localparam logic [VLW-1:0] LANE_IDX = VLW'(LANE_ID);
  localparam logic [VLW:0]   STRIDE   = (VLW+1)'(NUM_LANES);

  lane_seq_state_t  state_q, state_d;
  logic [VLW-1:0]   idx_q, idx_d;
  lane_fu_sel_t     fu_q;
  logic [VLW-1:0]   vl_q;
  logic             masked_q;
  logic [VLMAX-1:0] mask_q;

  logic             active;
  logic             abort;
  logic             issue_fire;
  logic             multi_cycle;
  logic [VLW:0]     next_idx;

  // Indices past VLMAX shift the probe bit out, so they read as masked-off.
  assign active      = !masked_q || |(mask_q & (VLMAX'(1) << idx_q));
  assign multi_cycle = (fu_q == FU_MUL) || (fu_q == FU_DIV);
  assign next_idx    = {1'b0, idx_q} + STRIDE;
  assign abort       = fu_exception &&
                       (state_q inside {ST_START, ST_WAIT, ST_COMMIT});
  assign issue_fire  = (state_q == ST_IDLE) && issue_valid && !flush;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    start_a    = 1'b0;
    start_mu   = 1'b0;
    start_div  = 1'b0;
    start_ma   = 1'b0;
    elem_wen   = 1'b0;
    instr_done = 1'b0;
    exception  = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
    end else if (abort) begin
      state_d   = ST_IDLE;
      exception = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (issue_valid) begin
            idx_d   = LANE_IDX;
            state_d = (LANE_IDX >= vl) ? ST_FIN : ST_START;
          end
        end
        ST_START: begin
          if (active) begin
            unique case (fu_q)
              FU_ALU:  start_a   = 1'b1;
              FU_MUL:  start_mu  = 1'b1;
              FU_DIV:  start_div = 1'b1;
              FU_MASK: start_ma  = 1'b1;
            endcase
          end
          state_d = (active && multi_cycle) ? ST_WAIT : ST_COMMIT;
        end
        ST_WAIT: begin
          if ((fu_q == FU_MUL && done_mu) || (fu_q == FU_DIV && done_du))
            state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          if (!stall_e_m) begin
            elem_wen = active;
            if (next_idx >= {1'b0, vl_q}) begin
              state_d = ST_FIN;
            end else begin
              idx_d   = next_idx[VLW-1:0];
              state_d = ST_START;
            end
          end
        end
        ST_FIN: begin
          instr_done = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= LANE_IDX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the instruction payload is not reset; it is always loaded at issue
  // before anything reads it, so a reset would only add fan-out.
  always_ff @(posedge CLK) begin
    if (issue_fire) begin
      fu_q     <= lane_fu_sel_t'(fu_sel);
      vl_q     <= vl;
      masked_q <= is_masked;
      mask_q   <= mask_bits;
    end
  end

  assign issue_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign next_busy   = (state_d != ST_IDLE);
  assign offset      = idx_q;

endmodule

// File: tb/tb_vector_lane_fu_sequencer.sv
// Directed bench for vector_lane_fu_sequencer: lanes 0 and 1 of a two-lane setup.
module tb_vector_lane_fu_sequencer;

  localparam int VLW   = 6;
  localparam int VLMAX = 32;
  localparam int MAXC  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       issue_valid;
  logic [1:0]       fu_sel;
  logic [VLW-1:0]   vl;
  logic             is_masked;
  logic [VLMAX-1:0] mask_bits;
  logic             done_mu, done_du, fu_exception, stall_e_m, flush;

  logic [1:0] issue_ready, start_a, start_mu, start_div, start_ma;
  logic [1:0] elem_wen, busy, next_busy, instr_done, exception;
  logic [VLW-1:0] offset [2];

  vector_lane_fu_sequencer #(.NUM_LANES(2), .LANE_ID(0), .VLMAX(VLMAX), .VLW(VLW)) u_lane0 (
    .CLK(clk), .RST(rst), .issue_valid(issue_valid[0]), .issue_ready(issue_ready[0]),
    .fu_sel(fu_sel), .vl(vl), .is_masked(is_masked), .mask_bits(mask_bits),
    .done_mu(done_mu), .done_du(done_du), .fu_exception(fu_exception),
    .stall_e_m(stall_e_m), .flush(flush),
    .start_a(start_a[0]), .start_mu(start_mu[0]), .start_div(start_div[0]), .start_ma(start_ma[0]),
    .offset(offset[0]), .elem_wen(elem_wen[0]), .busy(busy[0]), .next_busy(next_busy[0]),
    .instr_done(instr_done[0]), .exception(exception[0])
  );

  vector_lane_fu_sequencer #(.NUM_LANES(2), .LANE_ID(1), .VLMAX(VLMAX), .VLW(VLW)) u_lane1 (
    .CLK(clk), .RST(rst), .issue_valid(issue_valid[1]), .issue_ready(issue_ready[1]),
    .fu_sel(fu_sel), .vl(vl), .is_masked(is_masked), .mask_bits(mask_bits),
    .done_mu(done_mu), .done_du(done_du), .fu_exception(fu_exception),
    .stall_e_m(stall_e_m), .flush(flush),
    .start_a(start_a[1]), .start_mu(start_mu[1]), .start_div(start_div[1]), .start_ma(start_ma[1]),
    .offset(offset[1]), .elem_wen(elem_wen[1]), .busy(busy[1]), .next_busy(next_busy[1]),
    .instr_done(instr_done[1]), .exception(exception[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle trace of the lane under test; cycle 1 is the first cycle after issue.
  logic           busy_a [MAXC];
  logic           nb_a   [MAXC];
  logic           wen_a  [MAXC];
  logic           done_a [MAXC];
  logic           exc_a  [MAXC];
  logic           ready_a[MAXC];
  logic [VLW-1:0] off_a  [MAXC];
  int n_sa, n_smu, n_sdiv, n_sma, n_wen, n_done, n_exc, busy_cyc, end_cyc;

  int   done_delay, stall_from, stall_len, flush_at, exc_at;
  logic du_noise;

  task automatic set_defaults();
    done_delay = 0;
    stall_from = 0;
    stall_len  = 0;
    flush_at   = 0;
    exc_at     = 0;
    du_noise   = 1'b0;
  endtask

  task automatic issue(input int lane, input logic [1:0] f, input logic [VLW-1:0] n,
                       input logic m, input logic [VLMAX-1:0] mb);
    @(negedge clk);
    fu_sel      = f;
    vl          = n;
    is_masked   = m;
    mask_bits   = mb;
    issue_valid = 2'b00;
    issue_valid[lane] = 1'b1;
    #1;
    n_checks++;
    if (issue_ready[lane] !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready_at_issue lane%0d: got %b want 1", lane, issue_ready[lane]);
    end
  endtask

  // Steps cycles after an issue, driving done/stall/flush/exception per the knobs,
  // until the lane reports idle or the cycle budget runs out.
  task automatic run(input int lane);
    int mu_due;
    bit seen_idle;
    mu_due    = -1;
    seen_idle = 1'b0;
    n_sa = 0; n_smu = 0; n_sdiv = 0; n_sma = 0;
    n_wen = 0; n_done = 0; n_exc = 0; busy_cyc = 0; end_cyc = -1;
    for (int i = 0; i < MAXC; i++) begin
      busy_a[i] = 1'b0; nb_a[i] = 1'b0; wen_a[i] = 1'b0; done_a[i] = 1'b0;
      exc_a[i] = 1'b0; ready_a[i] = 1'b0; off_a[i] = '0;
    end
    for (int c = 1; c < MAXC && !seen_idle; c++) begin
      @(negedge clk);
      issue_valid  = 2'b00;
      done_mu      = (mu_due == c) && (fu_sel == 2'd1);
      done_du      = ((mu_due == c) && (fu_sel == 2'd2)) || du_noise;
      stall_e_m    = (c >= stall_from) && (c < stall_from + stall_len);
      flush        = (c == flush_at);
      fu_exception = (c == exc_at);
      #1;
      busy_a[c]  = busy[lane];
      nb_a[c]    = next_busy[lane];
      wen_a[c]   = elem_wen[lane];
      done_a[c]  = instr_done[lane];
      exc_a[c]   = exception[lane];
      ready_a[c] = issue_ready[lane];
      off_a[c]   = offset[lane];
      if (start_a[lane])    n_sa++;
      if (start_mu[lane])   n_smu++;
      if (start_div[lane])  n_sdiv++;
      if (start_ma[lane])   n_sma++;
      if (elem_wen[lane])   n_wen++;
      if (instr_done[lane]) n_done++;
      if (exception[lane])  n_exc++;
      if ((start_mu[lane] || start_div[lane]) && done_delay > 0) mu_due = c + done_delay;
      if (busy[lane]) busy_cyc++;
      else begin
        seen_idle = 1'b1;
        end_cyc   = c;
      end
    end
    done_mu = 1'b0; done_du = 1'b0; stall_e_m = 1'b0; flush = 1'b0; fu_exception = 1'b0;
    n_checks++;
    if (!seen_idle) begin
      n_fail++;
      $display("FAIL timeout lane%0d: still busy after %0d cycles, want idle", lane, MAXC);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_valid = 2'b00; fu_sel = 2'd0; vl = '0; is_masked = 1'b0; mask_bits = '0;
    done_mu = 1'b0; done_du = 1'b0; fu_exception = 1'b0; stall_e_m = 1'b0; flush = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (issue_ready !== 2'b11 || busy !== 2'b00 || next_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready_busy: ready=%b busy=%b next_busy=%b want 11 00 00",
               issue_ready, busy, next_busy);
    end
    n_checks++;
    if ({start_a, start_mu, start_div, start_ma, elem_wen, instr_done, exception} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want all 0",
               {start_a, start_mu, start_div, start_ma, elem_wen, instr_done, exception});
    end
    n_checks++;
    if (offset[0] !== 6'd0 || offset[1] !== 6'd1) begin
      n_fail++;
      $display("FAIL reset_offset: got %0d/%0d want 0/1", offset[0], offset[1]);
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_alu();
    set_defaults();
    issue(0, 2'd0, 6'd5, 1'b0, '0);
    run(0);
    n_checks++;
    if (n_sa !== 3 || n_smu + n_sdiv + n_sma !== 0) begin
      n_fail++;
      $display("FAIL alu_starts: got a=%0d other=%0d want 3/0", n_sa, n_smu + n_sdiv + n_sma);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (wen_a[2 + 2*k] !== 1'b1 || off_a[2 + 2*k] !== 6'(2*k)) begin
        n_fail++;
        $display("FAIL alu_wen_elem%0d: cycle %0d wen=%b off=%0d want 1/%0d",
                 k, 2 + 2*k, wen_a[2 + 2*k], off_a[2 + 2*k], 2*k);
      end
    end
    n_checks++;
    if (n_wen !== 3 || done_a[7] !== 1'b1 || n_done !== 1) begin
      n_fail++;
      $display("FAIL alu_done: wen=%0d done@7=%b ndone=%0d want 3/1/1", n_wen, done_a[7], n_done);
    end
    n_checks++;
    if (busy_cyc !== 7 || end_cyc !== 8) begin
      n_fail++;
      $display("FAIL alu_busy: busy=%0d idle_at=%0d want 7/8", busy_cyc, end_cyc);
    end
    for (int c = 1; c < 8; c++) begin
      n_checks++;
      if (nb_a[c] !== busy_a[c+1]) begin
        n_fail++;
        $display("FAIL alu_next_busy cycle%0d: got %b want %b", c, nb_a[c], busy_a[c+1]);
      end
    end
  endtask

  task automatic test_mul();
    set_defaults();
    done_delay = 3;
    du_noise   = 1'b1;
    issue(1, 2'd1, 6'd4, 1'b0, '0);
    run(1);
    n_checks++;
    if (n_smu !== 2 || n_sa + n_sdiv + n_sma !== 0) begin
      n_fail++;
      $display("FAIL mul_starts: got mu=%0d other=%0d want 2/0", n_smu, n_sa + n_sdiv + n_sma);
    end
    n_checks++;
    if (wen_a[5] !== 1'b1 || off_a[5] !== 6'd1 || wen_a[10] !== 1'b1 || off_a[10] !== 6'd3) begin
      n_fail++;
      $display("FAIL mul_wen: c5 %b/%0d c10 %b/%0d want 1/1 1/3",
               wen_a[5], off_a[5], wen_a[10], off_a[10]);
    end
    n_checks++;
    if (n_wen !== 2 || done_a[11] !== 1'b1 || busy_cyc !== 11) begin
      n_fail++;
      $display("FAIL mul_total: wen=%0d done@11=%b busy=%0d want 2/1/11", n_wen, done_a[11], busy_cyc);
    end
  endtask

  task automatic test_masked();
    set_defaults();
    issue(0, 2'd0, 6'd4, 1'b1, 32'h0000_0001);
    run(0);
    n_checks++;
    if (n_sa !== 1) begin
      n_fail++;
      $display("FAIL masked_starts: got %0d want 1", n_sa);
    end
    n_checks++;
    if (wen_a[2] !== 1'b1 || off_a[2] !== 6'd0 || wen_a[4] !== 1'b0 || off_a[4] !== 6'd2) begin
      n_fail++;
      $display("FAIL masked_commit: c2 %b/%0d c4 %b/%0d want 1/0 0/2",
               wen_a[2], off_a[2], wen_a[4], off_a[4]);
    end
    n_checks++;
    if (n_wen !== 1 || done_a[5] !== 1'b1 || end_cyc !== 6) begin
      n_fail++;
      $display("FAIL masked_done: wen=%0d done@5=%b idle_at=%0d want 1/1/6", n_wen, done_a[5], end_cyc);
    end
  endtask

  task automatic test_empty();
    set_defaults();
    issue(0, 2'd0, 6'd0, 1'b0, '0);
    run(0);
    n_checks++;
    if (n_sa + n_smu + n_sdiv + n_sma !== 0 || n_wen !== 0 || done_a[1] !== 1'b1 || end_cyc !== 2) begin
      n_fail++;
      $display("FAIL empty_vl0: starts=%0d wen=%0d done@1=%b idle_at=%0d want 0/0/1/2",
               n_sa + n_smu + n_sdiv + n_sma, n_wen, done_a[1], end_cyc);
    end
    issue(1, 2'd1, 6'd1, 1'b0, '0);
    run(1);
    n_checks++;
    if (n_sa + n_smu + n_sdiv + n_sma !== 0 || n_wen !== 0 || done_a[1] !== 1'b1 || end_cyc !== 2) begin
      n_fail++;
      $display("FAIL empty_lane1_vl1: starts=%0d wen=%0d done@1=%b idle_at=%0d want 0/0/1/2",
               n_sa + n_smu + n_sdiv + n_sma, n_wen, done_a[1], end_cyc);
    end
  endtask

  task automatic test_stall();
    set_defaults();
    stall_from = 2;
    stall_len  = 3;
    issue(0, 2'd0, 6'd2, 1'b0, '0);
    run(0);
    for (int c = 2; c < 5; c++) begin
      n_checks++;
      if (wen_a[c] !== 1'b0 || off_a[c] !== 6'd0 || busy_a[c] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold cycle%0d: wen=%b off=%0d busy=%b want 0/0/1",
                 c, wen_a[c], off_a[c], busy_a[c]);
      end
    end
    n_checks++;
    if (wen_a[5] !== 1'b1 || off_a[5] !== 6'd0 || n_wen !== 1 || done_a[6] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: wen@5=%b off=%0d nwen=%0d done@6=%b want 1/0/1/1",
               wen_a[5], off_a[5], n_wen, done_a[6]);
    end
  endtask

  task automatic test_flush_exception();
    set_defaults();
    flush_at = 3;
    issue(0, 2'd2, 6'd2, 1'b0, '0);
    run(0);
    n_checks++;
    if (n_sdiv !== 1 || n_wen !== 0 || n_done !== 0 || n_exc !== 0 || end_cyc !== 4 || ready_a[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_div: div=%0d wen=%0d done=%0d exc=%0d idle_at=%0d want 1/0/0/0/4",
               n_sdiv, n_wen, n_done, n_exc, end_cyc);
    end

    set_defaults();
    exc_at = 3;
    issue(0, 2'd2, 6'd2, 1'b0, '0);
    run(0);
    n_checks++;
    if (exc_a[3] !== 1'b1 || n_exc !== 1 || n_wen !== 0 || n_done !== 0 || end_cyc !== 4 || ready_a[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL exception_div: exc@3=%b nexc=%0d wen=%0d done=%0d idle_at=%0d want 1/1/0/0/4",
               exc_a[3], n_exc, n_wen, n_done, end_cyc);
    end

    set_defaults();
    flush_at = 3;
    exc_at   = 3;
    issue(0, 2'd2, 6'd2, 1'b0, '0);
    run(0);
    n_checks++;
    if (n_exc !== 0 || end_cyc !== 4) begin
      n_fail++;
      $display("FAIL flush_over_exception: exc=%0d idle_at=%0d want 0/4", n_exc, end_cyc);
    end

    set_defaults();
    done_delay = 3;
    exc_at     = 4;
    issue(0, 2'd1, 6'd2, 1'b0, '0);
    run(0);
    n_checks++;
    if (exc_a[4] !== 1'b1 || n_wen !== 0 || n_done !== 0 || end_cyc !== 5) begin
      n_fail++;
      $display("FAIL exception_over_done: exc@4=%b wen=%0d done=%0d idle_at=%0d want 1/0/0/5",
               exc_a[4], n_wen, n_done, end_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_masked();
    test_empty();
    test_stall();
    test_flush_exception();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
